// File: rtl/demux_1_4_stream.sv
// 1:4 packet stream demultiplexer with a single full-throughput output register.
// Optional per-channel output beat counters are enabled by defining DEMUX_BEAT_CNT_EN.
module demux_1_4_stream #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic              busy
`ifdef DEMUX_BEAT_CNT_EN
    ,
    output logic [63:0]       beat_cnt
`endif
);

    // state | meaning
    // IDLE  | no packet open; next accepted beat starts a packet and picks in_sel
    // BUSY  | packet open; beats follow cur_sel until the last beat is accepted
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state;
    logic [1:0]        cur_sel;
    logic              occ;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic [1:0]        dest;
    logic              accept;
    logic              drain;
    logic [1:0]        route_sel;

    assign in_ready  = rst_n && (!occ || out_ready[dest]);
    assign accept    = in_valid && in_ready;
    assign drain     = occ && out_ready[dest];
    assign route_sel = (state == ST_IDLE) ? in_sel : cur_sel;

    assign out_data = data_q;
    assign out_last = last_q;
    assign busy     = (state == ST_BUSY);

    always_comb begin
        out_valid = 4'b0000;
        if (occ) begin
            out_valid[dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cur_sel <= 2'd0;
            occ     <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            dest    <= 2'd0;
        end else if (accept) begin
            // A simultaneous drain is absorbed here: occ stays set and the new beat loads.
            occ    <= 1'b1;
            data_q <= in_data;
            last_q <= in_last;
            dest   <= route_sel;
            if (state == ST_IDLE) begin
                cur_sel <= in_sel;
            end
            state <= in_last ? ST_IDLE : ST_BUSY;
        end else if (drain) begin
            occ <= 1'b0;
        end
    end

`ifdef DEMUX_BEAT_CNT_EN
    logic [15:0] cnt [4];

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt[k] <= 16'd0;
            end else if (out_valid[k] && out_ready[k]) begin
                cnt[k] <= cnt[k] + 16'd1;
            end
        end
    end

    assign beat_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: directed vector table, hand sequences and a random
// run against a scoreboard model. Counter checks are included when DEMUX_BEAT_CNT_EN is defined.
module tb_demux_1_4_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       busy;
`ifdef DEMUX_BEAT_CNT_EN
    logic [63:0] beat_cnt;
`endif

    demux_1_4_stream #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef DEMUX_BEAT_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [1:0] dest;
    } beat_t;

    // Scoreboard: beats accepted but not yet handed downstream, in order.
    beat_t       q[$];
    logic        open_m;
    logic [1:0]  lock_m;
    int unsigned cnt_m [4];
    logic        chk_en;

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic       l;
        logic [3:0] rdy;
        logic [3:0] eov;
        logic [7:0] ed;
        logic       el;
        logic       eb;
        logic       eir;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] r;
        r = 4'b0000;
        r[s] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_ir();
        return (q.size() == 0) || out_ready[q[0].dest];
    endfunction

    task automatic model_reset();
        q.delete();
        open_m = 1'b0;
        lock_m = 2'd0;
        for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    endtask

    task automatic model_check();
        chk("out_valid", out_valid, (q.size() != 0) ? onehot(q[0].dest) : 4'b0000);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_last", out_last, q[0].last);
        end
        chk("in_ready", in_ready, exp_ir());
        chk("busy", busy, open_m);
    endtask

    // Apply inputs on the falling edge and let them settle before sampling.
    task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d,
                         input logic l, input logic [3:0] rdy);
        @(negedge clk);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        in_last   = l;
        out_ready = rdy;
        #1;
        if (chk_en) model_check();
    endtask

    // Cross the rising edge and advance the scoreboard by the rules of the handshake.
    task automatic advance();
        logic  acc, dr;
        beat_t b;
        acc = in_valid && exp_ir();
        dr  = (q.size() != 0) && out_ready[q[0].dest];
        @(posedge clk);
        if (dr) begin
            cnt_m[q[0].dest]++;
            void'(q.pop_front());
        end
        if (acc) begin
            b.data = in_data;
            b.last = in_last;
            b.dest = open_m ? lock_m : in_sel;
            q.push_back(b);
            if (!open_m) lock_m = in_sel;
            open_m = !in_last;
        end
    endtask

    task automatic step(input logic v, input logic [1:0] sel, input logic [7:0] d,
                        input logic l, input logic [3:0] rdy);
        drive(v, sel, d, l, rdy);
        advance();
    endtask

    int hs3;

    initial begin
        // Single beat, sel locking, then backpressure on channel 0 with other readies high.
        tbl[0]  = '{1'b1, 2'd2, 8'hA5, 1'b1, 4'b1111, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 2'd1, 8'h01, 1'b0, 4'b1111, 4'b0100, 8'hA5, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 2'd3, 8'h02, 1'b0, 4'b1111, 4'b0010, 8'h01, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 2'd0, 8'h03, 1'b1, 4'b1111, 4'b0010, 8'h02, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 4'b0010, 8'h03, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 2'd0, 8'h10, 1'b0, 4'b1110, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 2'd0, 8'h11, 1'b1, 4'b1110, 4'b0001, 8'h10, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 2'd0, 8'h11, 1'b1, 4'b1110, 4'b0001, 8'h10, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 2'd0, 8'h11, 1'b1, 4'b1111, 4'b0001, 8'h10, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 4'b0001, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1};

        chk_en    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 4'b0000;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst out_valid", out_valid, 4'b0000);
        chk("rst out_data", out_data, 8'h00);
        chk("rst out_last", out_last, 1'b0);
        chk("rst busy", busy, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].l, tbl[i].rdy);
            chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].eov);
            if (tbl[i].eov != 4'b0000) begin
                chk($sformatf("vec%0d out_data", i), out_data, tbl[i].ed);
                chk($sformatf("vec%0d out_last", i), out_last, tbl[i].el);
            end
            chk($sformatf("vec%0d busy", i), busy, tbl[i].eb);
            chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].eir);
            advance();
        end

        // Throughput: 16 back-to-back beats to channel 3.
        chk_en = 1'b1;
        hs3 = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16)
                drive(1'b1, (i == 0) ? 2'd3 : 2'(i), 8'(8'h40 + i), (i == 15), 4'b1000);
            else
                drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b1000);
            if (i > 0) begin
                chk("thru data", out_data, 8'(8'h40 + i - 1));
                if (out_valid[3] && out_ready[3]) hs3++;
            end
            advance();
        end
        chk("thru handshakes", hs3, 16);

        // Reset in the middle of a 4-beat packet.
        step(1'b1, 2'd2, 8'hB0, 1'b0, 4'b1111);
        step(1'b1, 2'd1, 8'hB1, 1'b0, 4'b1111);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 4'b0000);
        chk("midrst busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'd0, 8'hC7, 1'b1, 4'b1111);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b1111);
        chk("postrst out_valid", out_valid, 4'b0001);
        chk("postrst out_data", out_data, 8'hC7);
        advance();

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                 ($urandom_range(0, 2) == 0), 4'($urandom));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 4'b1111);

`ifdef DEMUX_BEAT_CNT_EN
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++)
            chk($sformatf("beat_cnt ch%0d", k), beat_cnt[16*k +: 16], 16'(cnt_m[k]));
        advance();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of the data path in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_data, input, DATA_W bits: upstream beat payload.
REQ-005 The block SHALL have port in_sel, input, 2 bits: destination channel 0..3, sampled on the first beat of a packet only.
REQ-006 The block SHALL have port in_last, input, 1 bit: marks the final beat of a packet.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 The block SHALL have port out_data, output, DATA_W bits: payload shared by all four channels.
REQ-010 The block SHALL have port out_last, output, 1 bit: last flag of the held beat.
REQ-011 The block SHALL have port out_valid, output, 4 bits: one-hot per-channel valid.
REQ-012 The block SHALL have port out_ready, input, 4 bits: per-channel downstream ready.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a packet is open (state BUSY).

Function
REQ-014 The input handshake SHALL complete when in_valid && in_ready on a rising edge.
- Output handshake on channel k: out_valid[k] && out_ready[k].
REQ-015 The block SHALL hold a single output register containing occ, data, last and dest[1:0].
- out_valid = occ ? onehot(dest) : 4'b0000.
- out_data and out_last driven from the register.
REQ-016 in_ready SHALL equal !occ || out_ready[dest], a full-throughput pipeline register.
- Bits of out_ready other than the dest bit are ignored.
REQ-017 An accepted beat SHALL appear on out_valid/out_data exactly 1 cycle after acceptance.
- Back-to-back beats SHALL sustain 1 beat/cycle while the destination keeps out_ready high.
REQ-018 The state machine SHALL have two states: IDLE and BUSY.
REQ-019 In IDLE, an accepted beat SHALL latch in_sel into cur_sel and be routed to in_sel.
- in_last=1: state stays IDLE (single-beat packet).
- in_last=0: state moves to BUSY.
REQ-020 In BUSY, accepted beats SHALL be routed to cur_sel, with in_sel ignored.
- An accepted beat with in_last=1 returns the state to IDLE.
REQ-021 With in_valid low, no state, register, or routing change SHALL occur except draining.
- Draining: occ clears on an output handshake when no new beat is accepted in the same cycle.
REQ-022 On simultaneous drain and accept in the same cycle, occ SHALL remain 1 and the register SHALL load the new beat.
REQ-023 A packet SHALL never be split across channels.
- A new packet may start in the cycle after the previous last beat is accepted.
REQ-024 Payload bits SHALL pass unmodified; no width conversion SHALL be performed.

Reset
REQ-025 While rst_n=0, the block SHALL hold the following values:
- state=IDLE, cur_sel=0, occ=0, out_valid=4'b0000, out_data=0, out_last=0, busy=0.
- in_ready=1 takes effect once rst_n is released.
REQ-026 Reset asserted mid-packet SHALL discard the held beat and the open packet; the first beat after release SHALL be treated as a new packet.

Configuration
REQ-027 The macro DEMUX_BEAT_CNT_EN SHALL, when defined, add output port beat_cnt (64 bits).
- beat_cnt is four 16-bit counters; channel k occupies bits [16k+15:16k].
- Each counter increments on every output handshake on its channel and wraps 16'hFFFF -> 0.
- Counters reset to 0 under rst_n.
REQ-028 When DEMUX_BEAT_CNT_EN is undefined, the beat_cnt port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Single-beat packet: in_sel=2, in_data=8'hA5, in_last=1, out_ready=4'b1111 -> next cycle out_valid=4'b0100, out_data=8'hA5, out_last=1; busy stays 0.
REQ-030 Sel locking: 3-beat packet (8'h01, 8'h02, 8'h03) with in_sel=1 then 3, 0 on later beats -> all three beats on out_valid=4'b0010; busy=1 until the last beat is accepted.
REQ-031 Backpressure: out_ready[0]=0 with 2 beats to channel 0 -> in_ready=0 after the first beat; raise out_ready[0] -> second beat delivered next cycle; nothing lost or duplicated; out_ready[3:1]=1 has no effect.
REQ-032 Throughput: 16 consecutive beats to channel 3 with out_ready=4'b1000 -> 16 handshakes in 16 consecutive cycles, 1-cycle latency.
REQ-033 Reset mid-packet: assert rst_n=0 after beat 2 of 4 -> out_valid=0, busy=0; after release, a beat with in_sel=0 goes to channel 0.
REQ-034 With DEMUX_BEAT_CNT_EN: 65537 beats to channel 1 -> beat_cnt[31:16]=1; other counters remain 0.
